// File: rtl/tmr_vote_capture.sv
// rtl/tmr_vote_capture.sv - majority voter for triplicated cell outputs with registered
// valid/ready output stage and sticky per-lane disagreement tracking.
module tmr_vote_capture #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] voted,
  output logic             err_a,
  output logic             err_b,
  output logic             err_c,
  output logic             multi_fault,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             clr_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] voted_q, voted_d;
  logic             err_a_q, err_a_d;
  logic             err_b_q, err_b_d;
  logic             err_c_q, err_c_d;
  logic             multi_q, multi_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic [WIDTH-1:0] vote;
  logic             m_a, m_b, m_c, m_multi, m_any;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  assign vote    = (a_in & b_in) | (b_in & c_in) | (a_in & c_in);
  assign m_a     = |(a_in ^ vote);
  assign m_b     = |(b_in ^ vote);
  assign m_c     = |(c_in ^ vote);
  assign m_multi = (m_a & m_b) | (m_b & m_c) | (m_a & m_c);
  assign m_any   = m_a | m_b | m_c;

  always_comb begin
    valid_d = valid_q;
    voted_d = voted_q;
    if (accept) begin
      valid_d = 1'b1;
      voted_d = vote;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end

    // clr_err zeroes the base first so an accepted beat in the same cycle still lands
    err_a_d = clr_err ? 1'b0 : err_a_q;
    err_b_d = clr_err ? 1'b0 : err_b_q;
    err_c_d = clr_err ? 1'b0 : err_c_q;
    multi_d = clr_err ? 1'b0 : multi_q;
    cnt_d   = clr_err ? '0 : cnt_q;
    if (accept) begin
      err_a_d = err_a_d | m_a;
      err_b_d = err_b_d | m_b;
      err_c_d = err_c_d | m_c;
      multi_d = multi_d | m_multi;
      if (m_any && (cnt_d != CNT_MAX)) begin
        cnt_d = cnt_d + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      voted_q <= '0;
      err_a_q <= 1'b0;
      err_b_q <= 1'b0;
      err_c_q <= 1'b0;
      multi_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      voted_q <= voted_d;
      err_a_q <= err_a_d;
      err_b_q <= err_b_d;
      err_c_q <= err_c_d;
      multi_q <= multi_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid   = valid_q;
  assign voted       = voted_q;
  assign err_a       = err_a_q;
  assign err_b       = err_b_q;
  assign err_c       = err_c_q;
  assign multi_fault = multi_q;
  assign err_cnt     = cnt_q;

endmodule

// File: tb/tb_tmr_vote_capture.sv
// tb/tb_tmr_vote_capture.sv - directed vector table, reset corner case and randomized
// run against a lane-counting reference model.
module tb_tmr_vote_capture;

  localparam int WIDTH = 2;
  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in, b_in, c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] voted;
  logic             err_a, err_b, err_c, multi_fault;
  logic [CNT_W-1:0] err_cnt;
  logic             clr_err;

  always #5 clk = ~clk;

  tmr_vote_capture #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .out_valid(out_valid),
    .out_ready(out_ready), .voted(voted), .err_a(err_a), .err_b(err_b),
    .err_c(err_c), .multi_fault(multi_fault), .err_cnt(err_cnt), .clr_err(clr_err)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Reference model: state after the most recent clock edge.
  int m_valid, m_voted, m_ea, m_eb, m_ec, m_multi, m_cnt;

  task automatic model_reset();
    m_valid = 0; m_voted = 0; m_ea = 0; m_eb = 0; m_ec = 0; m_multi = 0; m_cnt = 0;
  endtask

  task automatic model_step(input int a, input int b, input int c, input int v,
                            input int r, input int clr);
    int copies[3];
    int vote, wrong, lane_bad[3];
    bit acc;
    copies[0] = a; copies[1] = b; copies[2] = c;
    acc = (v != 0) && (m_valid == 0 || r != 0);
    vote = 0;
    for (int bit_i = 0; bit_i < WIDTH; bit_i++) begin
      int ones = 0;
      for (int l = 0; l < 3; l++) ones += (copies[l] >> bit_i) & 1;
      if (ones >= 2) vote += (1 << bit_i);
    end
    wrong = 0;
    for (int l = 0; l < 3; l++) begin
      lane_bad[l] = (copies[l] != vote) ? 1 : 0;
      wrong += lane_bad[l];
    end
    if (clr != 0) begin
      m_ea = 0; m_eb = 0; m_ec = 0; m_multi = 0; m_cnt = 0;
    end
    if (acc) begin
      m_valid = 1;
      m_voted = vote;
      if (lane_bad[0] != 0) m_ea = 1;
      if (lane_bad[1] != 0) m_eb = 1;
      if (lane_bad[2] != 0) m_ec = 1;
      if (wrong >= 2) m_multi = 1;
      if (wrong > 0 && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end else if (r != 0) begin
      m_valid = 0;
    end
  endtask

  task automatic drive(input int a, input int b, input int c, input int v,
                       input int r, input int clr);
    a_in = WIDTH'(a); b_in = WIDTH'(b); c_in = WIDTH'(c);
    in_valid = v[0]; out_ready = r[0]; clr_err = clr[0];
  endtask

  typedef struct {
    int a, b, c, v, r, clr;
    int e_voted, e_valid, e_ea, e_eb, e_ec, e_multi, e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int a, int b, int c, int v, int r, int clr,
                              int ev, int eval, int ea, int eb, int ec, int em, int ecnt);
    vec_t t;
    t.a = a; t.b = b; t.c = c; t.v = v; t.r = r; t.clr = clr;
    t.e_voted = ev; t.e_valid = eval; t.e_ea = ea; t.e_eb = eb; t.e_ec = ec;
    t.e_multi = em; t.e_cnt = ecnt;
    return t;
  endfunction

  initial begin
    //            a  b  c  v  r clr  voted val ea eb ec mf cnt
    vecs.push_back(mk(1, 1, 1, 1, 1, 0,  1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2, 3, 3, 1, 1, 0,  3, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0,  0, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2, 0, 1, 1, 0,  0, 1, 1, 1, 0, 1, 1));
    vecs.push_back(mk(3, 3, 3, 1, 1, 1,  3, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0,  3, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0,  3, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0,  3, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0,  0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(3, 0, 0, 1, 1, 0,  0, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(3, 0, 0, 1, 1, 0,  0, 1, 1, 0, 0, 0, 2));
    vecs.push_back(mk(3, 0, 0, 1, 1, 0,  0, 1, 1, 0, 0, 0, 3));
    vecs.push_back(mk(3, 0, 0, 1, 1, 0,  0, 1, 1, 0, 0, 0, 3));
    vecs.push_back(mk(3, 0, 0, 1, 1, 0,  0, 1, 1, 0, 0, 0, 3));
    vecs.push_back(mk(0, 0, 2, 1, 1, 1,  0, 1, 0, 0, 1, 0, 1));
    vecs.push_back(mk(3, 3, 3, 0, 1, 0,  0, 0, 0, 0, 1, 0, 1));

    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset out_valid", int'(out_valid), 0);
    check("reset voted", int'(voted), 0);
    check("reset flags", int'({err_a, err_b, err_c, multi_fault}), 0);
    check("reset err_cnt", int'(err_cnt), 0);

    foreach (vecs[i]) begin
      vec_t t = vecs[i];
      drive(t.a, t.b, t.c, t.v, t.r, t.clr);
      #1;
      check($sformatf("vec%0d in_ready", i), int'(in_ready),
            (m_valid == 0 || t.r != 0) ? 1 : 0);
      model_step(t.a, t.b, t.c, t.v, t.r, t.clr);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d voted", i), int'(voted), t.e_voted);
      check($sformatf("vec%0d out_valid", i), int'(out_valid), t.e_valid);
      check($sformatf("vec%0d err_a", i), int'(err_a), t.e_ea);
      check($sformatf("vec%0d err_b", i), int'(err_b), t.e_eb);
      check($sformatf("vec%0d err_c", i), int'(err_c), t.e_ec);
      check($sformatf("vec%0d multi", i), int'(multi_fault), t.e_multi);
      check($sformatf("vec%0d err_cnt", i), int'(err_cnt), t.e_cnt);
    end

    // Mid-operation reset: held word with flags set, reset must clear before any edge.
    drive(1, 2, 3, 1, 0, 0);
    model_step(1, 2, 3, 1, 0, 0);
    @(posedge clk);
    @(negedge clk);
    check("pre-rst out_valid", int'(out_valid), 1);
    check("pre-rst multi", int'(multi_fault), 1);
    rst = 1'b1;
    #1;
    check("async rst out_valid", int'(out_valid), 0);
    check("async rst voted", int'(voted), 0);
    check("async rst flags", int'({err_a, err_b, err_c, multi_fault}), 0);
    check("async rst err_cnt", int'(err_cnt), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1, 1, 1, 1, 1, 0);
    model_step(1, 1, 1, 1, 1, 0);
    @(posedge clk);
    @(negedge clk);
    check("post-rst voted", int'(voted), 1);
    check("post-rst out_valid", int'(out_valid), 1);
    check("post-rst flags", int'({err_a, err_b, err_c, multi_fault}), 0);
    check("post-rst err_cnt", int'(err_cnt), 0);

    for (int k = 0; k < 400; k++) begin
      int a, b, c, v, r, clr;
      a = int'($urandom_range(3)); b = int'($urandom_range(3)); c = int'($urandom_range(3));
      if ($urandom_range(99) < 50) begin
        b = a;
        c = ($urandom_range(1) == 1) ? a : c;
      end
      v = ($urandom_range(99) < 75) ? 1 : 0;
      r = ($urandom_range(99) < 65) ? 1 : 0;
      clr = ($urandom_range(99) < 4) ? 1 : 0;
      drive(a, b, c, v, r, clr);
      #1;
      check($sformatf("rnd%0d in_ready", k), int'(in_ready),
            (m_valid == 0 || r != 0) ? 1 : 0);
      model_step(a, b, c, v, r, clr);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("rnd%0d out_valid", k), int'(out_valid), m_valid);
      check($sformatf("rnd%0d voted", k), int'(voted), m_voted);
      check($sformatf("rnd%0d flags", k), int'({err_a, err_b, err_c, multi_fault}),
            (m_ea << 3) | (m_eb << 2) | (m_ec << 1) | m_multi);
      check($sformatf("rnd%0d err_cnt", k), int'(err_cnt), m_cnt);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
